// File: rtl/sandpile_frame_buffer_if.sv
// Simulator-to-frame-buffer cell-write channel (valid/ready with last marker).
interface sandpile_frame_buffer_if #(
  parameter int COORD_W = 5
);
  logic               wr_valid_i;
  logic               wr_ready_o;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [2:0]         wr_data;
  logic               wr_last_i;

  modport master (output wr_valid_i, wr_x, wr_y, wr_data, wr_last_i, input wr_ready_o);
  modport slave  (input wr_valid_i, wr_x, wr_y, wr_data, wr_last_i, output wr_ready_o);
endinterface

// File: rtl/sandpile_frame_buffer.sv
// Sandpile cell frame buffer: simulator writes snapshots, renderer reads with 1-cycle latency.
// Define SANDPILE_FB_DOUBLE_BUFFER_EN for two banks swapped on frame start; default is one bank.
module sandpile_frame_buffer #(
  parameter int MAX_SIZE = 32,
  parameter int COORD_W  = $clog2(MAX_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   new_frame_i,
  input  logic [8:0]             resolution,
  sandpile_frame_buffer_if.slave wr,
  input  logic [COORD_W-1:0]     stack_addr_x,
  input  logic [COORD_W-1:0]     stack_addr_y,
  output logic [2:0]             stack_data,
  output logic                   new_data
);
  localparam int DEPTH  = MAX_SIZE * MAX_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              swap, wr_fire, wr_hit, rd_hit, visible;
  logic [9:0]        eff;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [2:0]        rd_cell;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return ADDR_W'(32'(y) * 32'(MAX_SIZE) + 32'(x));
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input logic [9:0]         e);
    return (32'(x) < 32'(e)) && (32'(y) < 32'(e));
  endfunction

  assign eff = (32'(resolution) > 32'(MAX_SIZE)) ? 10'(MAX_SIZE) : 10'(resolution);

  assign wr.wr_ready_o = (state == FILL);
  assign wr_fire       = wr.wr_valid_i & wr.wr_ready_o;
  assign wr_hit        = wr_fire & in_range(wr.wr_x, wr.wr_y, eff);
  assign rd_hit        = visible & in_range(stack_addr_x, stack_addr_y, eff);
  assign wr_addr       = cell_addr(wr.wr_x, wr.wr_y);
  assign rd_addr       = cell_addr(stack_addr_x, stack_addr_y);

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      FILL: if (wr_fire && wr.wr_last_i) state_nxt = PEND;
      PEND: if (new_frame_i) begin
        state_nxt = FILL;
        swap      = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // visible only rises on a swap, so stale memory after power-up stays masked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      visible  <= 1'b0;
      new_data <= 1'b0;
    end else begin
      state    <= state_nxt;
      new_data <= swap;
      if (swap) visible <= 1'b1;
    end
  end

`ifdef SANDPILE_FB_DOUBLE_BUFFER_EN
  logic       rd_bank;
  logic [2:0] mem [2][DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_bank <= 1'b0;
    else        rd_bank <= rd_bank ^ swap;
  end

  // swap and writes are exclusive in time (PEND vs FILL), so ~rd_bank is stable per snapshot
  always_ff @(posedge clk) begin
    if (wr_hit) mem[~rd_bank][wr_addr] <= wr.wr_data;
  end

  assign rd_cell = mem[rd_bank][rd_addr];
`else
  logic [2:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_addr] <= wr.wr_data;
  end

  assign rd_cell = mem[rd_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stack_data <= 3'd0;
    else        stack_data <= rd_hit ? rd_cell : 3'd0;
  end
endmodule

// File: doc/sandpile_frame_buffer.md
SANDPILE_FRAME_BUFFER -- requirements
Module: sandpile_frame_buffer

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 32, maximum grid edge in cells.
REQ-002 SHALL have parameter COORD_W, default $clog2(MAX_SIZE), width of the cell coordinate.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port new_frame_i  input  1  one-cycle frame-start pulse from display timing.
REQ-006 SHALL have port resolution  input  9  active grid edge in cells.
REQ-007 SHALL have port wr_valid_i  input  1  simulator cell-write request.
REQ-008 SHALL have port wr_ready_o  output  1  buffer accepts a write this cycle.
REQ-009 SHALL have port wr_x, wr_y  input  COORD_W each  write cell coordinate.
REQ-010 SHALL have port wr_data  input  3  cell value (grain count).
REQ-011 SHALL have port wr_last_i  input  1  marks the final write of a snapshot.
REQ-012 SHALL have port stack_addr_x, stack_addr_y  input  COORD_W each  renderer read coordinate.
REQ-013 SHALL have port stack_data  output  3  registered read data.
REQ-014 SHALL have port new_data  output  1  one-cycle pulse when a new snapshot becomes visible.

Function
REQ-015 SHALL hold two banks of MAX_SIZE*MAX_SIZE 3-bit cells; rd_bank selects the read bank, the other bank is the write bank.
REQ-016 SHALL transfer a write when wr_valid_i and wr_ready_o are both 1; wr_ready_o SHALL depend only on state, never on wr_valid_i.
REQ-017 SHALL run states FILL (wr_ready_o=1), PEND (wr_ready_o=0); FILL->PEND on an accepted write with wr_last_i=1; PEND->FILL on new_frame_i=1.
REQ-018 On PEND->FILL SHALL invert rd_bank and pulse new_data for exactly that one cycle; set visible flag.
REQ-019 new_frame_i in FILL SHALL be ignored (no swap, no new_data).
REQ-020 A last write accepted in the same cycle as new_frame_i SHALL enter PEND; swap waits for the next new_frame_i.
REQ-021 Effective size eff = min(resolution, MAX_SIZE); writes with wr_x>=eff or wr_y>=eff SHALL complete the handshake but not modify memory.
REQ-022 stack_data SHALL equal cell (stack_addr_x, stack_addr_y) of the read bank one cycle after the address is presented (latency 1).
REQ-023 stack_data SHALL be 0 for addresses with x>=eff or y>=eff, or while visible flag is 0.
REQ-024 Writes SHALL never alter the read bank; a swap SHALL affect read data starting the cycle after new_data.
REQ-025 resolution=0 SHALL drop all writes and read 0 everywhere; handshake and swap still operate.

Reset
REQ-026 On rst_n=0 SHALL immediately force state=FILL, rd_bank=0, visible=0, stack_data=0, new_data=0, wr_ready_o=1.
REQ-027 Memory contents SHALL not be reset; visible=0 masks them until the first swap.
REQ-028 Reset mid-snapshot SHALL discard the partial snapshot; the next write sequence restarts from FILL.

Configuration
REQ-029 Macro SANDPILE_FB_DOUBLE_BUFFER_EN defined: behaviour per REQ-015..REQ-028.
REQ-030 Macro undefined: single bank; writes go directly to the read bank (visible immediately after 1 cycle); PEND/swap and new_data timing unchanged, rd_bank fixed 0.

Verification
REQ-031 After reset, read (3,3) -> stack_data=0, wr_ready_o=1, new_data=0.
REQ-032 Write (3,3)=5 with last, then new_frame_i -> new_data pulses 1 cycle; read (3,3) next cycle -> stack_data=5 one cycle later.
REQ-033 Second snapshot writes (3,3)=2 with last, no new_frame_i -> read (3,3) still 5, wr_ready_o=0; after new_frame_i -> 2.
REQ-034 resolution=16, write (20,4)=7 with last, swap -> handshake completes, read (20,4)=0, read (4,4)=previous value.
REQ-035 Last write coincident with new_frame_i -> no new_data that cycle; new_data on following new_frame_i.
REQ-036 rst_n low during FILL after 10 writes -> stack_data=0 asynchronously, state FILL, visible=0 until next completed swap.
